// File: rtl/sm_hex_display_scan_pkg.sv
// Shared glyph constants for the hex scanner: active-high {g,f,e,d,c,b,a} patterns.
package sm_hex_display_scan_pkg;

    localparam logic [6:0] SM_SEG_0     = 7'h3F;
    localparam logic [6:0] SM_SEG_1     = 7'h06;
    localparam logic [6:0] SM_SEG_2     = 7'h5B;
    localparam logic [6:0] SM_SEG_3     = 7'h4F;
    localparam logic [6:0] SM_SEG_4     = 7'h66;
    localparam logic [6:0] SM_SEG_5     = 7'h6D;
    localparam logic [6:0] SM_SEG_6     = 7'h7D;
    localparam logic [6:0] SM_SEG_7     = 7'h07;
    localparam logic [6:0] SM_SEG_8     = 7'h7F;
    localparam logic [6:0] SM_SEG_9     = 7'h6F;
    localparam logic [6:0] SM_SEG_A     = 7'h77;
    localparam logic [6:0] SM_SEG_B     = 7'h7C;
    localparam logic [6:0] SM_SEG_C     = 7'h39;
    localparam logic [6:0] SM_SEG_D     = 7'h5E;
    localparam logic [6:0] SM_SEG_E     = 7'h79;
    localparam logic [6:0] SM_SEG_F     = 7'h71;
    localparam logic [6:0] SM_SEG_BLANK = 7'h00;

endpackage

// File: rtl/sm_hex_display_scan_decoder.sv
// Combinational hex nibble to 7-segment glyph (active-high, b and d lowercase).
module sm_hex_decoder
    import sm_hex_display_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    always_comb begin
        glyph = SM_SEG_BLANK;
        case (nibble)
            4'h0: glyph = SM_SEG_0;
            4'h1: glyph = SM_SEG_1;
            4'h2: glyph = SM_SEG_2;
            4'h3: glyph = SM_SEG_3;
            4'h4: glyph = SM_SEG_4;
            4'h5: glyph = SM_SEG_5;
            4'h6: glyph = SM_SEG_6;
            4'h7: glyph = SM_SEG_7;
            4'h8: glyph = SM_SEG_8;
            4'h9: glyph = SM_SEG_9;
            4'hA: glyph = SM_SEG_A;
            4'hB: glyph = SM_SEG_B;
            4'hC: glyph = SM_SEG_C;
            4'hD: glyph = SM_SEG_D;
            4'hE: glyph = SM_SEG_E;
            4'hF: glyph = SM_SEG_F;
            default: glyph = SM_SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/sm_hex_display_scan.sv
// Time-multiplexed hex display scanner with per-frame snapshot of the data word.
// Optional leading-zero blanking is built when SM_HEX_DISPLAY_LZB_EN is defined.
module sm_hex_display_scan
    import sm_hex_display_scan_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 16,
    parameter int GUARD    = 4,
    parameter int SEG_LOW  = 1,
    parameter int AN_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic                  hold,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     anode,
    output logic                  frame
);

    localparam int                 IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [PRESCALE-1:0] GUARD_CNT = PRESCALE'(GUARD);
    localparam logic [6:0]         SEG_OFF   = (SEG_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0]  AN_OFF    = (AN_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRESCALE-1:0] pcnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [4*DIGITS-1:0] snap_reg;
    logic [6:0]          seg_reg;
    logic [DIGITS-1:0]   anode_reg;
    logic                frame_reg;

    logic                tick;
    logic                boundary;
    logic [3:0]          nib_arr [DIGITS];
    logic [3:0]          nibble;
    logic [6:0]          glyph;
    logic [6:0]          glyph_shown;
    logic [DIGITS-1:0]   an_act;

    assign tick     = &pcnt_reg;
    assign boundary = tick && (idx_reg == IDX_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = snap_reg[4*gi +: 4];
            // Anode stays dark for the first GUARD cycles of a slot to hide ghosting.
            assign an_act[gi]  = (idx_reg == IDX_W'(gi)) && (pcnt_reg >= GUARD_CNT);
        end
    endgenerate

    assign nibble = nib_arr[idx_reg];

    sm_hex_decoder u_decoder (
        .nibble (nibble),
        .glyph  (glyph)
    );

`ifdef SM_HEX_DISPLAY_LZB_EN
    logic [DIGITS-1:0] nz;
    logic [IDX_W-1:0]  msd;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nz
            assign nz[gi] = |snap_reg[4*gi +: 4];
        end
    endgenerate

    // msd stays 0 for an all-zero word, so digit 0 always shows.
    always_comb begin
        msd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (nz[i]) msd = IDX_W'(i);
        end
    end

    assign glyph_shown = (idx_reg > msd) ? SM_SEG_BLANK : glyph;
`else
    assign glyph_shown = glyph;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_reg  <= '0;
            idx_reg   <= '0;
            snap_reg  <= '0;
            seg_reg   <= SEG_OFF;
            anode_reg <= AN_OFF;
            frame_reg <= 1'b0;
        end else begin
            pcnt_reg <= pcnt_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            if (boundary && !hold) begin
                snap_reg <= data;
            end
            frame_reg <= boundary;
            anode_reg <= (AN_LOW != 0) ? ~an_act : an_act;
            seg_reg   <= (SEG_LOW != 0) ? ~glyph_shown : glyph_shown;
        end
    end

    assign seg   = seg_reg;
    assign anode = anode_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_sm_hex_display_scan.sv
// Directed bench for sm_hex_display_scan (DIGITS=4, PRESCALE=2, GUARD=1, active-low outputs).
module tb_sm_hex_display_scan;

    localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
    localparam logic [6:0] G5 = 7'h6D, GA = 7'h77, GB = 7'h7C, GC = 7'h39, GD = 7'h5E;
    localparam logic [6:0] OFF7 = 7'h7F;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] data = 16'h0000;
    logic        hold = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        frame;

    int errors = 0;
    int checks = 0;

    sm_hex_display_scan #(
        .DIGITS   (4),
        .PRESCALE (2),
        .GUARD    (1),
        .SEG_LOW  (1),
        .AN_LOW   (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .data  (data),
        .hold  (hold),
        .seg   (seg),
        .anode (anode),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic wait_anode(input logic [3:0] a, output bit found);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (anode === a) found = 1;
        end
    endtask

    task automatic wait_frame(output bit found);
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (frame === 1'b1) found = 1;
        end
    endtask

    // Waits for each digit slot in order 0..3 and compares its segments (active-low).
    task automatic check_digits(input string name, input logic [6:0] g0, input logic [6:0] g1,
                                input logic [6:0] g2, input logic [6:0] g3);
        logic [3:0] an_tab [4];
        logic [6:0] exp_tab [4];
        bit found;
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_tab = '{~g0, ~g1, ~g2, ~g3};
        for (int d = 0; d < 4; d++) begin
            wait_anode(an_tab[d], found);
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL %s digit%0d: anode %b never seen, required %b", name, d, anode, an_tab[d]);
            end else if (seg !== exp_tab[d]) begin
                errors++;
                $display("FAIL %s digit%0d: seg=%b required %b", name, d, seg, exp_tab[d]);
            end else begin
                $display("%s digit%0d seg=%b ok", name, d, seg);
            end
        end
    endtask

    task automatic check_restart(input string name);
        int early = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (n < 16 && frame !== 1'b0) early++;
            if (n == 1) begin
                checks++;
                if (anode !== 4'b1111) begin
                    errors++;
                    $display("FAIL %s guard: anode=%b required 1111", name, anode);
                end
            end
            if (n == 2) begin
                checks++;
                if (anode !== 4'b1110 || seg !== ~G0) begin
                    errors++;
                    $display("FAIL %s first digit: anode=%b seg=%b required 1110 %b", name, anode, seg, ~G0);
                end
            end
            if (n == 16) begin
                checks++;
                if (frame !== 1'b1 || early != 0) begin
                    errors++;
                    $display("FAIL %s frame timing: frame=%b early=%0d required 1 and 0", name, frame, early);
                end
            end
        end
        $display("%s restart sequence checked", name);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (anode !== 4'b1111 || seg !== OFF7 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: anode=%b seg=%h frame=%b required 1111 7f 0", anode, seg, frame);
        end else $display("reset_state ok");
        rst = 1'b0;
        check_restart("reset");
    endtask

    task automatic test_hold;
        bit found;
        data = 16'h1234;
        hold = 1'b0;
        repeat (2) begin
            wait_frame(found);
            checks++;
            if (!found) begin errors++; $display("FAIL hold frame: frame never pulsed, required 1"); end
        end
        check_digits("data1234", G4, G3, G2, G1);
        hold = 1'b1;
        data = 16'hABCD;
        repeat (3) wait_frame(found);
        check_digits("held1234", G4, G3, G2, G1);
        hold = 1'b0;
        wait_frame(found);
        check_digits("released", GD, GC, GB, GA);
    endtask

    task automatic test_free_run;
        int frames = 0, guards = 0, last_frame = -1, bad_gap = 0, bad_seq = 0;
        logic [3:0] prev_act = 4'b0000;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (frame === 1'b1) begin
                if (last_frame >= 0 && c - last_frame != 16) bad_gap++;
                last_frame = c;
                frames++;
            end
            if (anode === 4'b1111) guards++;
            else if (anode !== prev_act) begin
                if (prev_act !== 4'b0000 && anode !== {prev_act[2:0], prev_act[3]}) bad_seq++;
                prev_act = anode;
            end
        end
        checks++;
        if (frames != 4 || bad_gap != 0) begin
            errors++;
            $display("FAIL free_run frames: count=%0d bad_gaps=%0d required 4 and 0", frames, bad_gap);
        end else $display("free_run frames=%0d ok", frames);
        checks++;
        if (guards != 16) begin
            errors++;
            $display("FAIL free_run guard: blank cycles=%0d required 16", guards);
        end else $display("free_run guard cycles=%0d ok", guards);
        checks++;
        if (bad_seq != 0) begin
            errors++;
            $display("FAIL free_run order: bad steps=%0d required 0", bad_seq);
        end else $display("free_run digit order ok");
    endtask

    task automatic test_reset_mid;
        bit found;
        wait_anode(4'b1011, found);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!found || anode !== 4'b1111 || seg !== OFF7 || frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: found=%0d anode=%b seg=%h frame=%b required 1 1111 7f 0", found, anode, seg, frame);
        end else $display("reset_mid state ok");
        rst = 1'b0;
        check_restart("reset_mid");
    endtask

    task automatic test_lzb;
        bit found;
        data = 16'h0050;
        wait_frame(found);
`ifdef SM_HEX_DISPLAY_LZB_EN
        check_digits("lzb0050", G0, G5, 7'h00, 7'h00);
`else
        check_digits("lzb0050", G0, G5, G0, G0);
`endif
        data = 16'h0000;
        wait_frame(found);
        wait_frame(found);
`ifdef SM_HEX_DISPLAY_LZB_EN
        check_digits("lzb0000", G0, 7'h00, 7'h00, 7'h00);
`else
        check_digits("lzb0000", G0, G0, G0, G0);
`endif
    endtask

    initial begin
        test_reset;
        test_hold;
        test_free_run;
        test_reset_mid;
        test_lzb;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
